// File: rtl/dmem_access.sv
// Data-memory access unit: aligns loads/stores onto an 8-byte bus, extends load data, flags misalignment.
// Latency: 2 cycles from acceptance to done with same-cycle addr_ok/data_ok; misaligned access completes in 1.
// Backpressure: stall = req_valid & ~flush & (state != DONE); the bus request is held until addr_ok.
module dmem_access #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  input  logic            memread,
  input  logic            memwrite,
  input  logic [1:0]      msize,
  input  logic            mem_unsigned,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] wdata,
  input  logic            flush,
  output logic            dreq_valid,
  output logic [XLEN-1:0] dreq_addr,
  output logic [2:0]      dreq_size,
  output logic [7:0]      dreq_strobe,
  output logic [XLEN-1:0] dreq_data,
  input  logic            dresp_addr_ok,
  input  logic            dresp_data_ok,
  input  logic [XLEN-1:0] dresp_data,
  output logic [XLEN-1:0] memread_data,
  output logic            done,
  output logic            stall,
  output logic            misalign
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} stateT;

  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [2:0]      size;
    logic [7:0]      strobe;
    logic [XLEN-1:0] data;
  } dreqT;

  stateT           state;
  stateT           stateNext;
  dreqT            reqQ;
  dreqT            reqNew;
  logic [2:0]      offQ;
  logic [1:0]      sizeQ;
  logic            loadQ;
  logic            unsignedQ;
  logic            misQ;
  logic            flushedQ;
  logic [XLEN-1:0] resultQ;

  logic            accept;
  logic            aligned;
  logic            respTaken;
  logic            flushNow;
  logic [7:0]      sizeMask;

  // Shift the bus word down to the accessed bytes, then sign- or zero-extend to XLEN.
  function automatic logic [XLEN-1:0] extendLoad(input logic [XLEN-1:0] raw,
                                                 input logic [2:0] off,
                                                 input logic [1:0] sz,
                                                 input logic uns);
    logic [XLEN-1:0] s;
    s = raw >> {off, 3'b000};
    case (sz)
      2'd0:    extendLoad = {{(XLEN-8){~uns & s[7]}}, s[7:0]};
      2'd1:    extendLoad = {{(XLEN-16){~uns & s[15]}}, s[15:0]};
      2'd2:    extendLoad = {{(XLEN-32){~uns & s[31]}}, s[31:0]};
      default: extendLoad = s;
    endcase
  endfunction

  assign accept    = (state == IDLE) & req_valid & ~flush;
  assign respTaken = ((state == REQ) & dresp_addr_ok & dresp_data_ok) |
                     ((state == WAIT) & dresp_data_ok);
  // A flush seen on the completion cycle itself must also squash the result.
  assign flushNow  = flushedQ | flush;

  // Alignment check and the bus request that an accepted access will issue.
  always_comb begin
    aligned  = 1'b1;
    sizeMask = 8'h01;
    case (msize)
      2'd0: begin aligned = 1'b1;               sizeMask = 8'h01; end
      2'd1: begin aligned = ~addr[0];           sizeMask = 8'h03; end
      2'd2: begin aligned = (addr[1:0] == 2'b00);  sizeMask = 8'h0F; end
      default: begin aligned = (addr[2:0] == 3'b000); sizeMask = 8'hFF; end
    endcase
    reqNew        = '0;
    reqNew.addr   = {addr[XLEN-1:3], 3'b000};
    reqNew.size   = {1'b0, msize};
    reqNew.strobe = memwrite ? (sizeMask << addr[2:0]) : 8'h00;
    reqNew.data   = memwrite ? (wdata << {addr[2:0], 3'b000}) : '0;
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= stateNext;
  end

  // Next-state logic; data_ok before addr_ok in REQ is deliberately ignored.
  always_comb begin
    stateNext = state;
    case (state)
      IDLE: if (accept) stateNext = aligned ? REQ : DONE;
      REQ:  if (dresp_addr_ok) stateNext = dresp_data_ok ? DONE : WAIT;
      WAIT: if (dresp_data_ok) stateNext = DONE;
      default: stateNext = IDLE;
    endcase
  end

  // Capture request fields on acceptance, track squashes, and latch the load result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      reqQ      <= '0;
      offQ      <= '0;
      sizeQ     <= '0;
      loadQ     <= 1'b0;
      unsignedQ <= 1'b0;
      misQ      <= 1'b0;
      flushedQ  <= 1'b0;
      resultQ   <= '0;
    end else if (accept && aligned) begin
      reqQ      <= reqNew;
      offQ      <= addr[2:0];
      sizeQ     <= msize;
      loadQ     <= memread;
      unsignedQ <= mem_unsigned;
      misQ      <= 1'b0;
      flushedQ  <= 1'b0;
      resultQ   <= '0;
    end else if (accept) begin
      misQ      <= 1'b1;
      flushedQ  <= 1'b0;
      resultQ   <= '0;
    end else begin
      if (((state == REQ) || (state == WAIT)) && flush) flushedQ <= 1'b1;
      if (respTaken)
        resultQ <= (loadQ && !flushNow) ? extendLoad(dresp_data, offQ, sizeQ, unsignedQ) : '0;
    end
  end

  // Outputs decoded from state and held registers.
  always_comb begin
    dreq_valid   = (state == REQ);
    dreq_addr    = reqQ.addr;
    dreq_size    = reqQ.size;
    dreq_strobe  = reqQ.strobe;
    dreq_data    = reqQ.data;
    memread_data = resultQ;
    done         = (state == DONE) & ~flushedQ;
    misalign     = (state == DONE) & misQ & ~flushedQ;
    stall        = req_valid & ~flush & (state != DONE);
  end

endmodule
